sr_latch_bank: RTL



---
 rtl/sr_latch_bank.sv | 104 ++++++++++
 1 files changed

// File: rtl/sr_latch_bank.sv
// Bank of WIDTH independent clocked set/reset latches with per-bank conflict
// resolution and an optional minimum-on time that defers blocked resets.
module sr_latch_bank #(
   parameter int               WIDTH         = 4,
   parameter int               CONFLICT_MODE = 0,
   parameter int               MIN_ON        = 0,
   parameter int               CNT_W         = 8,
   parameter logic [WIDTH-1:0] INIT          = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] set,
   input  logic [WIDTH-1:0] reset,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] changed,
   output logic [WIDTH-1:0] conflict,
   output logic [WIDTH-1:0] pending,
   output logic [WIDTH-1:0] hold_busy
);

   localparam logic [CNT_W-1:0] MIN_ON_C = CNT_W'(MIN_ON);
   // With no minimum-on restriction the counter has nothing to measure, so it stays at 0.
   localparam logic [CNT_W-1:0] RISE_C   = (MIN_ON >= 1) ? CNT_W'(1) : '0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic             q_r, chg_r, conf_r, pend_r;
      logic             do_set, do_rst, allow_off, busy;
      logic             q_next, pend_next;

      if (MIN_ON > 0) begin : g_min_on
         assign allow_off = (cnt >= MIN_ON_C);
         assign busy      = q_r && (cnt < MIN_ON_C);
      end else begin : g_no_min_on
         assign allow_off = 1'b1;
         assign busy      = 1'b0;
      end

      always_comb begin
         do_set = 1'b0;
         do_rst = 1'b0;
         if (set[i] && !reset[i]) begin
            do_set = 1'b1;
         end else if (!set[i] && reset[i]) begin
            do_rst = 1'b1;
         end else if (set[i] && reset[i]) begin
            case (CONFLICT_MODE)
               0: do_rst = 1'b1;
               1: do_set = 1'b1;
               3: begin
                  if (q_r) do_rst = 1'b1;
                  else     do_set = 1'b1;
               end
               default: ;
            endcase
         end
      end

      always_comb begin
         q_next    = q_r;
         pend_next = pend_r;
         if (do_set) begin
            q_next    = 1'b1;
            pend_next = 1'b0;
         end else if (do_rst && q_r) begin
            if (allow_off) begin
               q_next    = 1'b0;
               pend_next = 1'b0;
            end else begin
               pend_next = 1'b1;
            end
         end else if (pend_r && allow_off) begin
            q_next    = 1'b0;
            pend_next = 1'b0;
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            q_r    <= INIT[i];
            chg_r  <= 1'b0;
            conf_r <= 1'b0;
            pend_r <= 1'b0;
            cnt    <= INIT[i] ? MIN_ON_C : '0;
         end else begin
            q_r    <= q_next;
            chg_r  <= q_next ^ q_r;
            conf_r <= set[i] & reset[i];
            pend_r <= pend_next;
            // Count on-time from the rising edge, saturating so it never wraps.
            if (!q_next)              cnt <= '0;
            else if (!q_r)            cnt <= RISE_C;
            else if (cnt < MIN_ON_C)  cnt <= cnt + CNT_W'(1);
         end
      end

      assign Q[i]         = q_r;
      assign changed[i]   = chg_r;
      assign conflict[i]  = conf_r;
      assign pending[i]   = pend_r;
      assign hold_busy[i] = busy;
   end

endmodule
